// File: rtl/lap_stopwatch_if.sv
// Button/read-back bundle between the stopwatch core and its front-end/display side.
// The master drives the active-low requests and the lap selector; the slave returns time and lap data.
interface lap_stopwatch_if #(
  parameter int LAP_DEPTH = 4
);
  localparam int LW = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;
  localparam int CW = $clog2(LAP_DEPTH + 1);

  logic          fStart;
  logic          fStop;
  logic          fLap;
  logic [LW-1:0] LapSel;
  logic [7:0]    Min;
  logic [7:0]    Sec;
  logic [7:0]    Csec;
  logic          Running;
  logic [CW-1:0] LapCnt;
  logic [7:0]    LapMin;
  logic [7:0]    LapSec;
  logic [7:0]    LapCsec;
  logic          LapOvf;
  logic          Wrap;

  modport master (
    output fStart, fStop, fLap, LapSel,
    input  Min, Sec, Csec, Running, LapCnt, LapMin, LapSec, LapCsec, LapOvf, Wrap
  );

  modport slave (
    input  fStart, fStop, fLap, LapSel,
    output Min, Sec, Csec, Running, LapCnt, LapMin, LapSec, LapCsec, LapOvf, Wrap
  );
endinterface

// File: rtl/lap_stopwatch.sv
// BCD mm:ss.cc stopwatch with start/pause toggle, clear and a small lap-capture buffer.
// Button requests are synchronised, edge-detected, and acted on two clocks after first being sampled low.
module lap_stopwatch #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int LAP_DEPTH = 4,
  parameter int MAX_MIN   = 59
) (
  input logic          Clk,
  input logic          Rst,
  lap_stopwatch_if.slave bus
);
  localparam int DIV = CLK_HZ / 100;
  localparam int PW  = $clog2(DIV);
  localparam int LW  = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;
  localparam int CW  = $clog2(LAP_DEPTH + 1);
  localparam int NE  = 1 << LW;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [7:0]    MIN_TOP    = 8'(((MAX_MIN / 10) * 16) + (MAX_MIN % 10));
  localparam logic [CW-1:0] LAP_FULL   = CW'(LAP_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  // Returns {carry, next}: wraps to 00 with carry when v has reached top.
  function automatic logic [8:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
    logic [8:0] r;
    if (v == top)             r = 9'h100;
    else if (v[3:0] == 4'd9)  r = {1'b0, v[7:4] + 4'd1, 4'd0};
    else                      r = {1'b0, v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  logic [2:0] sync_p0, sync_p1, sync_p2;
  logic [2:0] vld_p2;
  logic       start_ev, stop_ev, lap_ev;

  state_t        state;
  logic          running;
  logic [PW-1:0] presc;
  logic [7:0]    min_q, sec_q, csec_q;
  logic [CW-1:0] lap_cnt;
  logic          lap_ovf, wrap_q;
  logic [23:0]   lap_buf [0:NE-1];

  logic       tick;
  logic [8:0] csec_inc, sec_inc, min_inc;

  // Stage p0/p1: two-flop synchroniser; p2: history for falling-edge detection.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      sync_p0 <= '1;
      sync_p1 <= '1;
      sync_p2 <= '1;
    end else begin
      sync_p0 <= {bus.fLap, bus.fStop, bus.fStart};
      sync_p1 <= sync_p0;
      sync_p2 <= sync_p1;
    end
  end

  assign vld_p2   = sync_p2 & ~sync_p1;
  assign start_ev = vld_p2[0];
  assign stop_ev  = vld_p2[1];
  assign lap_ev   = vld_p2[2];

  always_comb begin
    tick     = (state == RUN) && (presc == PRESC_LAST);
    csec_inc = bcd_inc(csec_q, 8'h99);
    sec_inc  = bcd_inc(sec_q, 8'h59);
    min_inc  = bcd_inc(min_q, MIN_TOP);
  end

  // Control, timekeeping and lap capture; stop overrides every other request.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state   <= IDLE;
      running <= 1'b0;
      presc   <= '0;
      min_q   <= '0;
      sec_q   <= '0;
      csec_q  <= '0;
      lap_cnt <= '0;
      lap_ovf <= 1'b0;
      wrap_q  <= 1'b0;
      for (int i = 0; i < NE; i++) lap_buf[i] <= '0;
    end else if (stop_ev) begin
      state   <= IDLE;
      running <= 1'b0;
      presc   <= '0;
      min_q   <= '0;
      sec_q   <= '0;
      csec_q  <= '0;
      lap_cnt <= '0;
      lap_ovf <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      if (state == RUN) begin
        if (tick) begin
          presc  <= '0;
          csec_q <= csec_inc[7:0];
          if (csec_inc[8]) begin
            sec_q <= sec_inc[7:0];
            if (sec_inc[8]) begin
              min_q <= min_inc[7:0];
              if (min_inc[8]) wrap_q <= 1'b1;
            end
          end
        end else begin
          presc <= presc + PW'(1);
        end
        // Captured values are the pre-tick time of this cycle.
        if (lap_ev) begin
          if (lap_cnt < LAP_FULL) begin
            lap_buf[lap_cnt[LW-1:0]] <= {min_q, sec_q, csec_q};
            lap_cnt                  <= lap_cnt + CW'(1);
          end else begin
            lap_ovf <= 1'b1;
          end
        end
      end
      if (start_ev) begin
        case (state)
          IDLE, PAUSE: begin
            state   <= RUN;
            running <= 1'b1;
          end
          RUN: begin
            state   <= PAUSE;
            running <= 1'b0;
          end
          default: begin
            state   <= IDLE;
            running <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.Min     = min_q;
  assign bus.Sec     = sec_q;
  assign bus.Csec    = csec_q;
  assign bus.Running = running;
  assign bus.LapCnt  = lap_cnt;
  assign bus.LapOvf  = lap_ovf;
  assign bus.Wrap    = wrap_q;

  always_comb begin
    bus.LapMin  = '0;
    bus.LapSec  = '0;
    bus.LapCsec = '0;
    if (CW'(bus.LapSel) < lap_cnt) begin
      {bus.LapMin, bus.LapSec, bus.LapCsec} = lap_buf[bus.LapSel];
    end
  end
endmodule

// File: tb/tb_lap_stopwatch.sv
// Scoreboard bench for lap_stopwatch: dut_a (DIV=10, 2 laps) for control/lap behaviour,
// dut_b (DIV=2, MAX_MIN=1) for minute carry and wrap-around.
`timescale 1ns/1ps
module tb_lap_stopwatch;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lap_stopwatch_if #(.LAP_DEPTH(2)) ifa();
  lap_stopwatch_if #(.LAP_DEPTH(4)) ifb();

  lap_stopwatch #(.CLK_HZ(1000), .LAP_DEPTH(2), .MAX_MIN(59)) dut_a (
    .Clk(clk), .Rst(rst), .bus(ifa)
  );
  lap_stopwatch #(.CLK_HZ(200), .LAP_DEPTH(4), .MAX_MIN(1)) dut_b (
    .Clk(clk), .Rst(rst), .bus(ifb)
  );

  localparam int DA = 0, DB = 1;
  localparam int S_START = 0, S_STOP = 1, S_LAP = 2;

  localparam logic [63:0] M_RUN  = 64'h1 << 54;
  localparam logic [63:0] M_TIME = 64'hFF_FFFF << 30;
  localparam logic [63:0] M_LCNT = 64'hF << 26;
  localparam logic [63:0] M_OVF  = 64'h1 << 25;
  localparam logic [63:0] M_WRAP = 64'h1 << 24;
  localparam logic [63:0] M_LAP  = 64'hFF_FFFF;
  localparam logic [63:0] M_ALL  = {64{1'b1}};
  localparam logic [63:0] M_CTRL = M_RUN | M_TIME | M_LCNT | M_OVF | M_WRAP;

  function automatic logic [63:0] pk(input logic run, input logic [23:0] t, input logic [3:0] lc,
                                     input logic ovf, input logic wrap, input logic [23:0] lap);
    return {9'b0, run, t, lc, ovf, wrap, lap};
  endfunction

  logic [63:0] obs_a, obs_b;
  assign obs_a = pk(ifa.Running, {ifa.Min, ifa.Sec, ifa.Csec}, 4'(ifa.LapCnt), ifa.LapOvf, ifa.Wrap,
                    {ifa.LapMin, ifa.LapSec, ifa.LapCsec});
  assign obs_b = pk(ifb.Running, {ifb.Min, ifb.Sec, ifb.Csec}, 4'(ifb.LapCnt), ifb.LapOvf, ifb.Wrap,
                    {ifb.LapMin, ifb.LapSec, ifb.LapCsec});

  typedef struct {
    string       name;
    int          which;
    int          cyc;
    logic [63:0] val;
    logic [63:0] mask;
    bit          imm;
  } item_t;

  item_t sb[$];
  event  chk_ev;

  task automatic expect_at(input string name, input int which, input int c,
                           input logic [63:0] v, input logic [63:0] m, input bit imm);
    item_t it;
    it.name = name; it.which = which; it.cyc = c; it.val = v; it.mask = m; it.imm = imm;
    sb.push_back(it);
  endtask

  task automatic compare(input item_t it);
    logic [63:0] act;
    act = (it.which == DB) ? obs_b : obs_a;
    checks++;
    if ((act & it.mask) !== (it.val & it.mask)) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %h, expected %h", it.name, cyc, act & it.mask, it.val & it.mask);
    end
  endtask

  always @(negedge clk) begin : mon_clk
    int i;
    i = 0;
    while (i < sb.size()) begin
      if (!sb[i].imm && sb[i].cyc <= cyc) begin
        compare(sb[i]);
        sb.delete(i);
      end else begin
        i++;
      end
    end
  end

  always @(chk_ev) begin : mon_imm
    int j;
    j = 0;
    while (j < sb.size()) begin
      if (sb[j].imm) begin
        compare(sb[j]);
        sb.delete(j);
      end else begin
        j++;
      end
    end
  end

  task automatic at(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_in(input int which, input int sig, input logic v);
    if (which == DA) begin
      case (sig)
        S_START: ifa.fStart = v;
        S_STOP:  ifa.fStop  = v;
        default: ifa.fLap   = v;
      endcase
    end else begin
      case (sig)
        S_START: ifb.fStart = v;
        S_STOP:  ifb.fStop  = v;
        default: ifb.fLap   = v;
      endcase
    end
  endtask

  task automatic press(input int which, input int sig, input int c);
    at(c);
    set_in(which, sig, 1'b0);
    at(c + 1);
    set_in(which, sig, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete at cycle %0d, expected end by 26410", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    ifa.fStart = 1'b1; ifa.fStop = 1'b1; ifa.fLap = 1'b1; ifa.LapSel = '0;
    ifb.fStart = 1'b1; ifb.fStop = 1'b1; ifb.fLap = 1'b1; ifb.LapSel = '0;
    expect_at("reset_a", DA, 3, 64'h0, M_ALL, 0);
    expect_at("reset_b", DB, 3, 64'h0, M_ALL, 0);
    at(2);
    rst = 1'b0;

    // Start at edge 6 -> RUN at 8, first tick at 18, 1.00 s at 1008.
    expect_at("start_wait", DA, 7, pk(0, 24'h0, 0, 0, 0, 0), M_RUN, 0);
    expect_at("start_run", DA, 8, pk(1, 24'h0, 0, 0, 0, 0), M_RUN, 0);
    expect_at("csec_00", DA, 17, pk(1, 24'h000000, 0, 0, 0, 0), M_RUN | M_TIME, 0);
    expect_at("csec_01", DA, 18, pk(1, 24'h000001, 0, 0, 0, 0), M_RUN | M_TIME, 0);
    expect_at("sec_pre", DA, 1007, pk(1, 24'h000099, 0, 0, 0, 0), M_TIME, 0);
    expect_at("sec_01", DA, 1008, pk(1, 24'h000100, 0, 0, 0, 0), M_TIME, 0);
    press(DA, S_START, 5);

    // Stop and start on the same sample: stop wins.
    expect_at("stop_start", DA, 1013, pk(0, 24'h0, 0, 0, 0, 0), M_CTRL, 0);
    at(1010);
    ifa.fStart = 1'b0; ifa.fStop = 1'b0;
    at(1011);
    ifa.fStart = 1'b1; ifa.fStop = 1'b1;

    expect_at("lap_idle", DA, 1026, pk(0, 24'h0, 0, 0, 0, 0), M_RUN | M_LCNT | M_OVF, 0);
    press(DA, S_LAP, 1020);

    // RUN at 1033; tick 37 at 1403; pause at 1408 with prescaler 5; resume at 1923 -> tick at 1928.
    press(DA, S_START, 1030);
    expect_at("pause_frozen", DA, 1409, pk(0, 24'h000037, 0, 0, 0, 0), M_RUN | M_TIME, 0);
    expect_at("pause_idle500", DA, 1909, pk(0, 24'h000037, 0, 0, 0, 0), M_RUN | M_TIME, 0);
    press(DA, S_START, 1405);
    expect_at("resume_hold", DA, 1927, pk(1, 24'h000037, 0, 0, 0, 0), M_RUN | M_TIME, 0);
    expect_at("resume_tick", DA, 1928, pk(1, 24'h000038, 0, 0, 0, 0), M_RUN | M_TIME, 0);
    press(DA, S_START, 1920);

    expect_at("stop_clear", DA, 1943, pk(0, 24'h0, 0, 0, 0, 0), M_CTRL, 0);
    press(DA, S_STOP, 1940);

    // RUN at 2003; laps at 00:00.05, 00:00.12, 00:00.20 with a 2-entry buffer.
    press(DA, S_START, 2000);
    press(DA, S_LAP, 2055);
    at(2060);
    ifa.LapSel = 1'b1;
    expect_at("lap1_sel_oob", DA, 2060, pk(0, 24'h0, 1, 0, 0, 24'h0), M_LCNT | M_OVF | M_LAP, 0);
    press(DA, S_LAP, 2125);
    press(DA, S_LAP, 2205);
    expect_at("lap_full_sel1", DA, 2210, pk(0, 24'h0, 2, 1, 0, 24'h000012), M_LCNT | M_OVF | M_LAP, 0);
    at(2211);
    ifa.LapSel = 1'b0;
    expect_at("lap_sel0", DA, 2211, pk(0, 24'h0, 2, 1, 0, 24'h000005), M_LCNT | M_OVF | M_LAP, 0);

    // Held start: single toggle at 2223 (which is also tick 22).
    expect_at("held_pause", DA, 2230, pk(0, 24'h0, 0, 0, 0, 0), M_RUN, 0);
    expect_at("held_single", DA, 2275, pk(0, 24'h000022, 0, 0, 0, 0), M_RUN | M_TIME, 0);
    at(2220);
    ifa.fStart = 1'b0;
    at(2270);
    ifa.fStart = 1'b1;
    expect_at("held_resume", DA, 2283, pk(1, 24'h0, 0, 0, 0, 0), M_RUN, 0);
    press(DA, S_START, 2280);

    // Asynchronous reset between clock edges.
    at(2300);
    #2;
    rst = 1'b1;
    #1;
    expect_at("async_reset", DA, cyc, 64'h0, M_ALL, 1);
    -> chk_ev;
    at(2302);
    rst = 1'b0;
    expect_at("post_reset", DA, 2310, pk(0, 24'h0, 0, 0, 0, 0), M_RUN | M_TIME | M_LCNT, 0);

    // dut_b: RUN at 2403, one tick every 2 clocks.
    expect_at("b_min_carry", DB, 14403, pk(1, 24'h010000, 0, 0, 0, 0), M_RUN | M_TIME | M_WRAP, 0);
    expect_at("b_top", DB, 26401, pk(1, 24'h015999, 0, 0, 0, 0), M_RUN | M_TIME | M_WRAP, 0);
    expect_at("b_top_hold", DB, 26402, pk(1, 24'h015999, 0, 0, 0, 0), M_RUN | M_TIME | M_WRAP, 0);
    expect_at("b_wrap", DB, 26403, pk(1, 24'h000000, 0, 0, 1, 0), M_RUN | M_TIME | M_WRAP, 0);
    press(DB, S_START, 2400);

    at(26410);
    foreach (sb[k]) begin
      checks++;
      errors++;
      $display("FAIL %s: never compared, expected %h at cycle %0d", sb[k].name, sb[k].val & sb[k].mask, sb[k].cyc);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
